// File: rtl/add_pkg.sv
// Shared definitions for the Execute-stage adder and the condition-code register.
package add_pkg;

    localparam int WIDTH = 64;

    localparam int CF_OF = 2;
    localparam int CF_SF = 1;
    localparam int CF_ZF = 0;

    typedef logic [2:0] cf_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell; the core chains WIDTH of these into a ripple adder.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_64bit_core.sv
// Registered two's-complement ripple adder with OF/SF/ZF condition flags.
// Operands are taken on every edge where in_valid is high and the registered result appears one cycle later.
module add_64bit_core #(
    parameter int WIDTH = add_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       cf_add
);

    import add_pkg::*;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    cf_t              flags;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder_1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    // Overflow is the carry disagreement across the sign bit; the final carry is otherwise dropped.
    always_comb begin
        flags        = '0;
        flags[CF_OF] = carry[WIDTH-1] ^ carry[WIDTH];
        flags[CF_SF] = sum[WIDTH-1];
        flags[CF_ZF] = ~|sum;
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    cf_t              cf_q, cf_d;

    always_comb begin
        out_valid_d = in_valid;
        out_d       = out_q;
        cf_d        = cf_q;
        if (in_valid) begin
            out_d = sum;
            cf_d  = flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            cf_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            cf_q        <= cf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign cf_add    = cf_q;

endmodule

// File: tb/tb_add_64bit_core.sv
// Self-checking bench for add_64bit_core: directed boundary cases plus random and shifted-ones streams.
module tb_add_64bit_core;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] out;
    logic [2:0]   cf_add;

    int checks = 0;
    int errors = 0;

    logic [W+2:0] exp_q[$];
    logic [W+2:0] last_exp;

    add_64bit_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out       (out),
        .cf_add    (cf_add)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: sign-extend to W+1 bits and add as integers; overflow when the
    // true signed sum does not fit in W bits.
    function automatic logic [W+2:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0]   ext;
        logic [W-1:0] s;
        logic         of, sf, zf;
        ext = {av[W-1], av} + {bv[W-1], bv};
        s   = ext[W-1:0];
        of  = ext[W] != ext[W-1];
        sf  = s[W-1];
        zf  = (s == '0);
        return {of, sf, zf, s};
    endfunction

    task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W+2:0] e;
        @(negedge clk);
        in_valid = v;
        a        = av;
        b        = bv;
        if (v) exp_q.push_back(model(av, bv));
        @(posedge clk);
        #1;
        check("out_valid", W'(out_valid), W'(v));
        if (v) begin
            e = exp_q.pop_front();
            check("out", out, e[W-1:0]);
            check("cf_add", W'(cf_add), W'(e[W+2:W]));
            last_exp = e;
        end else begin
            check("hold_out", out, last_exp[W-1:0]);
            check("hold_cf", W'(cf_add), W'(last_exp[W+2:W]));
        end
    endtask

    task automatic directed(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] eo, input logic [2:0] ecf);
        step(1'b1, av, bv);
        check({tag, "_out"}, out, eo);
        check({tag, "_cf"}, W'(cf_add), W'(ecf));
    endtask

    initial begin
        logic [W-1:0] sa, sb;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        last_exp = '0;
        #1;
        check("rst_out", out, '0);
        check("rst_cf", W'(cf_add), '0);
        check("rst_valid", W'(out_valid), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        directed("pp",   64'd11,  64'd4,                 64'd15,                 3'b000);
        directed("np",  -64'd11,  64'd4,                -64'd7,                  3'b010);
        directed("nn",  -64'd11, -64'd4,                -64'd15,                 3'b010);
        directed("pn",   64'd11, -64'd4,                 64'd7,                  3'b000);
        directed("povf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 3'b110);
        directed("zero", 64'd11, -64'd11,               64'd0,                  3'b001);
        directed("novf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 3'b101);

        step(1'b0, 64'd1, 64'd2);
        step(1'b0, 64'd3, 64'd4);

        // shifted-ones stream, back-to-back
        sa = -64'd11;
        sb = -64'd4;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, sa, sb);
            sa = ~((~sa) << 2);
            sb = ~((~sb) << 4);
        end

        // random stream with occasional idle cycles and boundary-biased operands
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = -ra;
                1: ra = {1'b0, {(W-1){1'b1}}};
                2: ra = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            step($urandom_range(0, 4) != 0, ra, rb);
        end

        // asynchronous reset mid-stream with in_valid high
        step(1'b1, 64'd100, 64'd23);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 64'd5;
        b        = 64'd6;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out", out, '0);
        check("arst_cf", W'(cf_add), '0);
        check("arst_valid", W'(out_valid), '0);
        @(posedge clk);
        #1;
        check("rsthold_out", out, '0);
        check("rsthold_valid", W'(out_valid), '0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        last_exp = '0;
        step(1'b0, 64'd0, 64'd0);
        directed("post_rst", 64'd40, 64'd2, 64'd42, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
